// File: rtl/mc_if.sv
// mc_if: instruction fields, ALU flags and datapath control strobes of the multicycle controller
interface mc_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       RegWrite;
  logic [1:0] ALUControl;
  logic [3:0] State;
  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, State
  );
  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, State
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset controller, Moore FSM with conditional execution and NZCV flags
module mc_controller (
  input logic clk,
  input logic reset,
  mc_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;
  state_t state, next;
  logic [3:0] nzcv;
  logic [3:0] cmd;
  logic [1:0] alu_dp;
  logic n, z, c, v, cond_ex, cmp, flag_we;
  assign cmd = bus.Funct[4:1];
  assign cmp = cmd == 4'b1010;
  assign {n, z, c, v} = nzcv;
  assign alu_dp = cmd == 4'b0100 ? 2'b00 :
                  (cmd == 4'b0010 || cmp) ? 2'b01 :
                  cmd == 4'b0000 ? 2'b10 :
                  cmd == 4'b1100 ? 2'b11 : 2'b00;
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // cond_ex here still sees the old flags, so the update never affects its own instruction
  assign flag_we = (state == EXECR || state == EXECI) && cond_ex && bus.Funct[0];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      nzcv  <= 4'b0000;
    end else begin
      state <= next;
      if (flag_we) begin
        nzcv[3:2] <= bus.ALUFlags[3:2];
        if (!alu_dp[1]) nzcv[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: next = bus.Op == 2'b01 ? MEMADR :
                     bus.Op == 2'b10 ? BRANCH :
                     bus.Op == 2'b00 ? (bus.Funct[5] ? EXECI : EXECR) : FETCH;
      MEMADR: next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  next = MEMWB;
      EXECR:  next = ALUWB;
      EXECI:  next = ALUWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.ALUControl = 2'b00;
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD:  bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = cond_ex;
      end
      MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_ex;
      end
      EXECR:  bus.ALUControl = alu_dp;
      EXECI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dp;
      end
      ALUWB: begin
        bus.RegWrite = cond_ex && !cmp;
        bus.PCWrite  = cond_ex && !cmp && bus.Rd == 4'd15;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = cond_ex;
      end
      default: ;
    endcase
  end
  assign bus.ImmSrc = bus.Op;
  assign bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.State  = state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed checks of state sequence, control strobes and flag behaviour
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  mc_if bus();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [11:0] pk(logic pcw, logic adr, logic mw, logic ir, logic [1:0] rs,
                                     logic asa, logic [1:0] asb, logic rw, logic [1:0] ac);
    return {pcw, adr, mw, ir, rs, asa, asb, rw, ac};
  endfunction
  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic look(string tag, logic [3:0] st, logic [11:0] o);
    chk({tag, ".state"}, {8'd0, bus.State}, {8'd0, st});
    chk({tag, ".ctl"}, {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                        bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ALUControl}, o);
  endtask
  task automatic cyc(string tag, logic [3:0] st, logic [11:0] o);
    @(posedge clk);
    @(negedge clk);
    look(tag, st, o);
  endtask
  task automatic instr(logic [3:0] c, logic [1:0] op, logic [5:0] f, logic [3:0] rd, logic [3:0] fl);
    bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = fl;
  endtask
  task automatic branch(string tag, logic [3:0] c, logic pcw);
    instr(c, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc({tag, ".dec"}, 4'd1, pk(0,0,0,0,2,1,2,0,0));
    cyc(tag, 4'd9, pk(pcw,0,0,0,2,0,1,0,0));
    cyc({tag, ".end"}, 4'd0, pk(1,0,0,1,2,1,2,0,0));
  endtask
  logic [11:0] o_fetch, o_dec, o_madr;
  initial begin
    o_fetch = pk(1,0,0,1,2,1,2,0,0);
    o_dec   = pk(0,0,0,0,2,1,2,0,0);
    o_madr  = pk(0,0,0,0,0,0,1,0,0);
    reset = 1'b0;
    instr(4'b1110, 2'b00, 6'b101001, 4'd3, 4'b0100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    look("reset", 4'd0, o_fetch);
    reset = 1'b1;
    cyc("adds.dec", 4'd1, o_dec);
    chk("adds.immsrc", {10'd0, bus.ImmSrc}, 12'd0);
    chk("adds.regsrc", {10'd0, bus.RegSrc}, 12'd0);
    cyc("adds.execi", 4'd7, pk(0,0,0,0,0,0,1,0,0));
    cyc("adds.aluwb", 4'd8, pk(0,0,0,0,0,0,0,1,0));
    cyc("adds.end", 4'd0, o_fetch);
    instr(4'b1110, 2'b01, 6'b011001, 4'd3, 4'b1111);
    cyc("ldr.dec", 4'd1, o_dec);
    cyc("ldr.memadr", 4'd2, o_madr);
    chk("ldr.immsrc", {10'd0, bus.ImmSrc}, 12'd1);
    chk("ldr.regsrc", {10'd0, bus.RegSrc}, 12'd2);
    cyc("ldr.memrd", 4'd3, pk(0,1,0,0,0,0,0,0,0));
    cyc("ldr.memwb", 4'd4, pk(0,0,0,0,1,0,0,1,0));
    cyc("ldr.end", 4'd0, o_fetch);
    instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc("str.dec", 4'd1, o_dec);
    cyc("str.memadr", 4'd2, o_madr);
    cyc("str.memwr", 4'd5, pk(0,1,1,0,0,0,0,0,0));
    cyc("str.end", 4'd0, o_fetch);
    chk("b.immsrc_pre", {10'd0, bus.ImmSrc}, 12'd1);
    branch("bne_z1", 4'b0001, 1'b0);
    chk("b.regsrc", {10'd0, bus.RegSrc}, 12'd1);
    branch("beq_z1", 4'b0000, 1'b1);
    instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0110);
    cyc("cmp.dec", 4'd1, o_dec);
    cyc("cmp.execr", 4'd6, pk(0,0,0,0,0,0,0,0,1));
    cyc("cmp.aluwb", 4'd8, pk(0,0,0,0,0,0,0,0,0));
    cyc("cmp.end", 4'd0, o_fetch);
    branch("bcs_c1", 4'b0010, 1'b1);
    branch("bvs_v0", 4'b0110, 1'b0);
    instr(4'b1110, 2'b00, 6'b000001, 4'd2, 4'b1000);
    cyc("ands.dec", 4'd1, o_dec);
    cyc("ands.execr", 4'd6, pk(0,0,0,0,0,0,0,0,2));
    cyc("ands.aluwb", 4'd8, pk(0,0,0,0,0,0,0,1,0));
    cyc("ands.end", 4'd0, o_fetch);
    branch("bhi_c1z0", 4'b1000, 1'b1);
    branch("bge_n1v0", 4'b1010, 1'b0);
    branch("bmi_n1", 4'b0100, 1'b1);
    instr(4'b1111, 2'b00, 6'b101001, 4'd4, 4'b0100);
    cyc("nv.dec", 4'd1, o_dec);
    cyc("nv.execi", 4'd7, pk(0,0,0,0,0,0,1,0,0));
    cyc("nv.aluwb", 4'd8, pk(0,0,0,0,0,0,0,0,0));
    cyc("nv.end", 4'd0, o_fetch);
    branch("beq_kept", 4'b0000, 1'b0);
    instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
    cyc("addpc.dec", 4'd1, o_dec);
    cyc("addpc.execr", 4'd6, pk(0,0,0,0,0,0,0,0,0));
    cyc("addpc.aluwb", 4'd8, pk(1,0,0,0,0,0,0,1,0));
    cyc("addpc.end", 4'd0, o_fetch);
    instr(4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000);
    cyc("rld.dec", 4'd1, o_dec);
    cyc("rld.memadr", 4'd2, o_madr);
    cyc("rld.memrd", 4'd3, pk(0,1,0,0,0,0,0,0,0));
    reset = 1'b0;
    cyc("rld.reset", 4'd0, o_fetch);
    reset = 1'b1;
    branch("bhi_clr", 4'b1000, 1'b0);
    branch("bmi_clr", 4'b0100, 1'b0);
    branch("bne_clr", 4'b0001, 1'b1);
    instr(4'b1110, 2'b11, 6'b111111, 4'd15, 4'b1111);
    cyc("op11.dec", 4'd1, o_dec);
    cyc("op11.end", 4'd0, o_fetch);
    cyc("op11.next", 4'd1, o_dec);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
